mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage feeding WB: takes EX results, performs data-memory load/store over a req/ack
//  handshake, registers alu_out, pc_inc2, ex_cond, mr_data, WB control and dst_reg for the WB stage.
//  Non-memory ops pass through with 1-cycle latency; memory ops stall upstream until ack or timeout.
// PARAMETERS
//  DW       16  data/address width
//  MAX_WAIT 8   cycles in BUSY without mem_ack before the access is abandoned (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  in_valid        in   1   EX presents a valid instruction
//  alu_out         in   DW  ALU result / memory address
//  wr_data         in   DW  store data
//  pc_inc2         in   DW  PC+2
//  ex_cond         in   1   condition result
//  in_MEM_control  in   2   {mem_write, mem_read}
//  in_WB_control   in   3   {reg_write, reg_src[1:0]}
//  dst_reg         in   3   destination register
//  stall           out  1   upstream must hold inputs this cycle
//  mem_req/mem_we  out  1   memory request / write enable
//  mem_addr        out  DW  memory address
//  mem_wdata       out  DW  memory write data
//  mem_rdata       in   DW  memory read data, valid with mem_ack
//  mem_ack         in   1   memory completes request this cycle
//  out_valid       out  1   WB-bound register holds a real instruction
//  out_alu_out, out_pc_inc2, mr_data  out DW; out_ex_cond out 1; out_WB_control out 3; out_dst_reg out 3
//  err             out  1   one-cycle pulse: access failed (timeout / misalign)
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait count=0, every output 0; mem_req drops immediately, even mid-access.
//  - mem_op = in_valid & (mem_read|mem_write); mem_write has priority if both set (treated as store).
//  - IDLE, no mem_op: stall=0; at edge output regs load inputs, out_valid=in_valid, mr_data=0.
//  - IDLE, mem_op: stall=1; at edge latch addr/wdata/we + all WB-bound fields, go BUSY, wait count=0;
//    output regs load bubble (out_valid=0, out_WB_control=0).
//  - BUSY: mem_req=1; mem_addr/mem_we/mem_wdata come from latches, stable until exit.
//    * mem_ack=1: stall=0; at edge outputs load latched fields, mr_data=mem_rdata if load else 0,
//      out_valid=1, state=IDLE. Upstream advances on this same edge (next instr sampled in IDLE).
//    * no ack, count==MAX_WAIT-1: timeout; stall=0; at edge outputs load latched fields with
//      out_WB_control[2]=0, mr_data=0, out_valid=1, err=1 for one cycle, state=IDLE.
//    * no ack otherwise: stall=1, count+1, output regs hold bubble.
//    * ack and timeout same cycle: ack wins, no err.
//  - mem_req outside BUSY is 0; mem_ack outside BUSY is ignored.
//  - out_valid=0 always forces out_WB_control=3'b000 so WB never writes on a bubble.
//  - Stored data never appears on mr_data; reg_write for stores passes as given by EX control.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: mem_op with alu_out[0]=1 is misaligned; no BUSY, no mem_req, stall=0,
//    completes at next edge with out_valid=1, out_WB_control[2]=0, mr_data=0, err=1.
//  ALIGN_CHECK_EN undefined: no check; full address including bit 0 goes to mem_addr, err only on timeout.
// TESTING
//  1 ALU op alu_out=0x1234, WB ctl=3'b100, dst=3 -> next cycle out_alu_out=0x1234, out_valid=1, stall=0 always.
//  2 Load addr 0x0040, ack 2 cycles after mem_req rises, rdata=0xBEEF, WB ctl=3'b111 -> stall high 3 cycles,
//    mem_req high 3 cycles, then mr_data=0xBEEF, out_valid=1, err=0.
//  3 Store addr 0x0010 wdata 0x5A5A, ack 1 cycle after mem_req rises -> mem_we=1, mem_addr/wdata stable
//    until ack, mr_data=0, out_valid=1.
//  4 MAX_WAIT=4, load with no ack -> mem_req high exactly 4 cycles, err pulse 1 cycle,
//    out_WB_control[2]=0, out_valid=1.
//  5 rst asserted mid-BUSY -> mem_req, stall, out_valid fall without clock edge; after release
//    an ALU op completes in 1 cycle.
//  6 Load at 0x0041: with ALIGN_CHECK_EN -> no mem_req, err=1 next cycle, reg_write 0; without ->
//    mem_addr=0x0041 requested normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: req/ack data-memory access with timeout, WB-bound registers.
// Optional ALIGN_CHECK_EN: odd-address memory ops complete at once with err and no write-back.
module mem_stage #(
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] pc_inc2,
    input  logic          ex_cond,
    input  logic [1:0]    in_MEM_control,
    input  logic [2:0]    in_WB_control,
    input  logic [2:0]    dst_reg,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          out_valid,
    output logic [DW-1:0] out_alu_out,
    output logic [DW-1:0] out_pc_inc2,
    output logic [DW-1:0] mr_data,
    output logic          out_ex_cond,
    output logic [2:0]    out_WB_control,
    output logic [2:0]    out_dst_reg,
    output logic          err
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_count, w_count_next;

    logic [DW-1:0]   r_addr, r_wdata, r_pc;
    logic            r_we, r_cond;
    logic [2:0]      r_wb, r_dst;

    logic            r_out_valid, r_out_cond, r_err;
    logic [DW-1:0]   r_out_alu, r_out_pc, r_mr_data;
    logic [2:0]      r_out_wb, r_out_dst;

    logic            w_out_valid, w_out_cond, w_err;
    logic [DW-1:0]   w_out_alu, w_out_pc, w_mr_data;
    logic [2:0]      w_out_wb, w_out_dst;

    logic            w_mem_op, w_misalign, w_latch, w_stall;

    assign w_mem_op = in_valid & (in_MEM_control[1] | in_MEM_control[0]);
`ifdef ALIGN_CHECK_EN
    assign w_misalign = w_mem_op & alu_out[0];
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_latch      = 1'b0;
        w_stall      = 1'b0;
        w_out_valid  = 1'b0;
        w_out_alu    = '0;
        w_out_pc     = '0;
        w_out_cond   = 1'b0;
        w_out_wb     = 3'b000;
        w_out_dst    = 3'b000;
        w_mr_data    = '0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_misalign) begin
                    w_out_valid = 1'b1;
                    w_out_alu   = alu_out;
                    w_out_pc    = pc_inc2;
                    w_out_cond  = ex_cond;
                    w_out_wb    = {1'b0, in_WB_control[1:0]};
                    w_out_dst   = dst_reg;
                    w_err       = 1'b1;
                end else if (w_mem_op) begin
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_state_next = S_BUSY;
                    w_count_next = '0;
                end else begin
                    w_out_valid = in_valid;
                    w_out_alu   = alu_out;
                    w_out_pc    = pc_inc2;
                    w_out_cond  = ex_cond;
                    w_out_wb    = in_valid ? in_WB_control : 3'b000;
                    w_out_dst   = dst_reg;
                end
            end
            S_BUSY: begin
                if (mem_ack || r_count == LAST_CNT) begin
                    // Ack takes precedence over a timeout landing on the same cycle.
                    w_state_next = S_IDLE;
                    w_out_valid  = 1'b1;
                    w_out_alu    = r_addr;
                    w_out_pc     = r_pc;
                    w_out_cond   = r_cond;
                    w_out_dst    = r_dst;
                    w_out_wb     = mem_ack ? r_wb : {1'b0, r_wb[1:0]};
                    w_mr_data    = (mem_ack && !r_we) ? mem_rdata : '0;
                    w_err        = ~mem_ack;
                end else begin
                    w_stall      = 1'b1;
                    w_count_next = r_count + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_we    <= 1'b0;
            r_cond  <= 1'b0;
            r_wb    <= 3'b000;
            r_dst   <= 3'b000;
        end else if (w_latch) begin
            r_addr  <= alu_out;
            r_wdata <= wr_data;
            r_pc    <= pc_inc2;
            r_we    <= in_MEM_control[1];
            r_cond  <= ex_cond;
            r_wb    <= in_WB_control;
            r_dst   <= dst_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_alu   <= '0;
            r_out_pc    <= '0;
            r_out_cond  <= 1'b0;
            r_out_wb    <= 3'b000;
            r_out_dst   <= 3'b000;
            r_mr_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid;
            r_out_alu   <= w_out_alu;
            r_out_pc    <= w_out_pc;
            r_out_cond  <= w_out_cond;
            r_out_wb    <= w_out_wb;
            r_out_dst   <= w_out_dst;
            r_mr_data   <= w_mr_data;
            r_err       <= w_err;
        end
    end

    // Stall is combinational from live inputs, so it is masked while reset is held.
    assign stall          = w_stall & ~rst;
    assign mem_req        = (r_state == S_BUSY);
    assign mem_we         = mem_req & r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign out_valid      = r_out_valid;
    assign out_alu_out    = r_out_alu;
    assign out_pc_inc2    = r_out_pc;
    assign mr_data        = r_mr_data;
    assign out_ex_cond    = r_out_cond;
    assign out_WB_control = r_out_wb;
    assign out_dst_reg    = r_out_dst;
    assign err            = r_err;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: each instruction's expected outcome is derived at
// transaction level (stall length, result fields, err) from the ack delay the bench chooses.
module tb_mem_stage;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] alu_out = '0, wr_data = '0, pc_inc2 = '0, mem_rdata = '0;
    logic          ex_cond = 1'b0, mem_ack = 1'b0;
    logic [1:0]    in_MEM_control = 2'b00;
    logic [2:0]    in_WB_control = 3'b000, dst_reg = 3'b000;
    logic          stall, mem_req, mem_we, out_valid, out_ex_cond, err;
    logic [DW-1:0] mem_addr, mem_wdata, out_alu_out, out_pc_inc2, mr_data;
    logic [2:0]    out_WB_control, out_dst_reg;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out), .wr_data(wr_data),
        .pc_inc2(pc_inc2), .ex_cond(ex_cond), .in_MEM_control(in_MEM_control),
        .in_WB_control(in_WB_control), .dst_reg(dst_reg), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .out_valid(out_valid), .out_alu_out(out_alu_out),
        .out_pc_inc2(out_pc_inc2), .mr_data(mr_data), .out_ex_cond(out_ex_cond),
        .out_WB_control(out_WB_control), .out_dst_reg(out_dst_reg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // delay = BUSY cycles before ack; delay >= MAX_WAIT means memory never answers.
    task automatic do_instr(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] pc, input logic c, input logic [1:0] mc,
                            input logic [2:0] wb, input logic [2:0] dst, input int delay,
                            input logic [DW-1:0] rd);
        logic is_mem, we, mis, timeout;
        int   n;
        is_mem = v && (mc != 2'b00);
        we     = mc[1];
`ifdef ALIGN_CHECK_EN
        mis = is_mem && a[0];
`else
        mis = 1'b0;
`endif
        @(negedge clk);
        in_valid = v; alu_out = a; wr_data = wd; pc_inc2 = pc; ex_cond = c;
        in_MEM_control = mc; in_WB_control = wb; dst_reg = dst;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
        #1;
        if (!is_mem || mis) begin
            check("stall_pass", 32'(stall), 32'(1'b0));
            check("req_pass", 32'(mem_req), 32'(1'b0));
            @(posedge clk); #1;
            check("valid_pass", 32'(out_valid), 32'(v));
            check("alu_pass", 32'(out_alu_out), 32'(a));
            check("pc_pass", 32'(out_pc_inc2), 32'(pc));
            check("cond_pass", 32'(out_ex_cond), 32'(c));
            check("dst_pass", 32'(out_dst_reg), 32'(dst));
            check("wb_pass", 32'(out_WB_control), mis ? 32'({1'b0, wb[1:0]}) : (v ? 32'(wb) : 32'd0));
            check("mr_pass", 32'(mr_data), 32'd0);
            check("err_pass", 32'(err), 32'(mis));
            $display("txn pass v=%0d addr=%h mc=%b mis=%0d", v, a, mc, mis);
        end else begin
            check("stall_start", 32'(stall), 32'd1);
            check("req_start", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            check("valid_bubble0", 32'(out_valid), 32'd0);
            check("wb_bubble0", 32'(out_WB_control), 32'd0);
            check("err_bubble0", 32'(err), 32'd0);
            timeout = (delay >= MAX_WAIT);
            n = timeout ? MAX_WAIT : delay + 1;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                in_valid = 1'($urandom); alu_out = DW'($urandom); wr_data = DW'($urandom);
                pc_inc2 = DW'($urandom); in_MEM_control = 2'($urandom);
                in_WB_control = 3'($urandom); dst_reg = 3'($urandom);
                mem_ack = (!timeout && k == delay);
                mem_rdata = mem_ack ? rd : DW'($urandom);
                #1;
                check("req_busy", 32'(mem_req), 32'd1);
                check("addr_busy", 32'(mem_addr), 32'(a));
                check("we_busy", 32'(mem_we), 32'(we));
                check("wdata_busy", 32'(mem_wdata), 32'(wd));
                check("stall_busy", 32'(stall), (k == n - 1) ? 32'd0 : 32'd1);
                @(posedge clk); #1;
                if (k == n - 1) begin
                    check("valid_done", 32'(out_valid), 32'd1);
                    check("alu_done", 32'(out_alu_out), 32'(a));
                    check("pc_done", 32'(out_pc_inc2), 32'(pc));
                    check("cond_done", 32'(out_ex_cond), 32'(c));
                    check("dst_done", 32'(out_dst_reg), 32'(dst));
                    check("wb_done", 32'(out_WB_control), timeout ? 32'({1'b0, wb[1:0]}) : 32'(wb));
                    check("mr_done", 32'(mr_data), (!timeout && !we) ? 32'(rd) : 32'd0);
                    check("err_done", 32'(err), 32'(timeout));
                end else begin
                    check("valid_bubble", 32'(out_valid), 32'd0);
                    check("err_bubble", 32'(err), 32'd0);
                end
            end
            $display("txn mem addr=%h we=%0d delay=%0d timeout=%0d", a, we, delay, timeout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b1; in_MEM_control = 2'b01; alu_out = 16'h0040;
        @(posedge clk); #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wb", 32'(out_WB_control), 32'd0);
        check("rst_alu", 32'(out_alu_out), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;

        do_instr(1'b1, 16'h1234, 16'h0, 16'h0102, 1'b1, 2'b00, 3'b100, 3'd3, 0, 16'h0);
        do_instr(1'b1, 16'h0040, 16'h0, 16'h0104, 1'b0, 2'b01, 3'b111, 3'd1, 2, 16'hBEEF);
        do_instr(1'b1, 16'h0010, 16'h5A5A, 16'h0106, 1'b0, 2'b10, 3'b010, 3'd0, 1, 16'h1111);
        do_instr(1'b1, 16'h0020, 16'h0, 16'h0108, 1'b1, 2'b01, 3'b101, 3'd2, 99, 16'h0);
        do_instr(1'b1, 16'h0022, 16'h0, 16'h010A, 1'b0, 2'b01, 3'b101, 3'd6, MAX_WAIT - 1, 16'h7777);
        do_instr(1'b1, 16'h0024, 16'h3C3C, 16'h010C, 1'b0, 2'b11, 3'b100, 3'd5, 0, 16'h9999);
        do_instr(1'b0, 16'h0026, 16'h0, 16'h010E, 1'b0, 2'b01, 3'b111, 3'd7, 0, 16'h0);
        do_instr(1'b1, 16'h0041, 16'h0, 16'h0110, 1'b0, 2'b01, 3'b110, 3'd4, 0, 16'hCAFE);

        // Reset in the middle of an access.
        @(negedge clk);
        in_valid = 1'b1; alu_out = 16'h0080; in_MEM_control = 2'b01; in_WB_control = 3'b111;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        #1;
        check("midrst_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        $display("txn reset mid-access");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        do_instr(1'b1, 16'h4321, 16'h0, 16'h0200, 1'b1, 2'b00, 3'b101, 3'd2, 0, 16'h0);

        for (int i = 0; i < 200; i++) begin
            do_instr(($urandom_range(0, 9) < 8), DW'($urandom), DW'($urandom), DW'($urandom),
                     1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                     int'($urandom_range(0, MAX_WAIT + 1)), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
